// File: rtl/bt_status_tx.sv
// rtl/bt_status_tx.sv - status frame transmitter for the Bluetooth UART return path
module bt_status_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_song_select,
  input  logic       i_pause,
  input  logic [3:0] i_vol_level,
  input  logic       i_req,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [1:0]        byte_idx;
  logic [3:0]        evt;
  logic [7:0]        status;
  logic [3:0]        pend;
  logic [2:0]        last_song;
  logic              last_pause;
  logic [3:0]        last_vol;

  logic [3:0] cond;
  logic       launch;
  logic       baud_done;
  logic [7:0] cur_byte;

  assign cond      = {i_req, i_vol_level != last_vol, i_pause != last_pause, i_song_select != last_song};
  assign launch    = (state == IDLE) && (pend != 4'd0);
  assign baud_done = (baud_cnt == BAUD_LAST);

  // Select the byte currently being shifted out: header, event mask, status, checksum
  always_comb begin
    cur_byte = 8'hA5;
    case (byte_idx)
      2'd0:    cur_byte = 8'hA5;
      2'd1:    cur_byte = {4'h0, evt};
      2'd2:    cur_byte = status;
      default: cur_byte = {4'h0, evt} ^ status;
    endcase
  end

  // Sticky change flags; on launch the snapshot catches up, so only a same-edge request survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 4'd0;
    end else if (launch) begin
      pend <= {i_req, 3'b000};
    end else begin
      pend <= pend | cond;
    end
  end

  // Frame sequencer: 4 back-to-back 8N1 bytes, snapshot taken at launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
      evt        <= 4'd0;
      status     <= 8'd0;
      last_song  <= 3'd0;
      last_pause <= 1'b1;
      last_vol   <= 4'd0;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pend != 4'd0) begin
            evt        <= pend;
            status     <= {i_pause, i_song_select, i_vol_level};
            last_song  <= i_song_select;
            last_pause <= i_pause;
            last_vol   <= i_vol_level;
            byte_idx   <= 2'd0;
            o_tx       <= 1'b0;
            o_busy     <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            o_tx     <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              o_tx     <= 1'b0;
              state    <= START;
            end else begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bt_status_tx.sv
// tb/tb_bt_status_tx.sv - self-checking bench for bt_status_tx
module tb_bt_status_tx;

  localparam int C = 10;

  logic       clk;
  logic       rst_n;
  logic [2:0] i_song_select;
  logic       i_pause;
  logic [3:0] i_vol_level;
  logic       i_req;
  logic       o_tx;
  logic       o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] rx_q[$];
  int         st_q[$];
  int         stop_err = 0;
  logic       mon_prev;
  logic [7:0] mon_b;
  int         mon_s;
  bit         mon_abort;

  logic [7:0] m_last;

  bt_status_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_song_select (i_song_select),
    .i_pause       (i_pause),
    .i_vol_level   (i_vol_level),
    .i_req         (i_req),
    .o_tx          (o_tx),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic skip_neg(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst_n) mon_abort = 1'b1;
    end
  endtask

  // Reference UART receiver: samples mid-bit on falling edges
  initial begin
    mon_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && mon_prev && !o_tx) begin
        mon_s = cyc;
        mon_abort = 1'b0;
        skip_neg(C + C / 2);
        for (int i = 0; i < 8; i++) begin
          mon_b[i] = o_tx;
          if (i < 7) skip_neg(C);
        end
        skip_neg(C);
        if (!mon_abort) begin
          if (o_tx !== 1'b1) stop_err++;
          rx_q.push_back(mon_b);
          st_q.push_back(mon_s);
        end
      end
      mon_prev = o_tx;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    i_pause = 1'b1;
    i_song_select = 3'd0;
    i_vol_level = 4'd0;
    i_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rx_q.delete();
    st_q.delete();
    m_last = 8'h80;
  endtask

  task automatic expect_frame(input string tag, input logic [3:0] evt, input logic [7:0] st,
                              output int start);
    int n;
    logic [7:0] b0, b1, b2, b3, e1;
    n = 0;
    start = -1;
    while (rx_q.size() < 4 && n < 1500) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_rx"}, 32'(rx_q.size() >= 4), 32'd1);
    if (rx_q.size() >= 4) begin
      b0 = rx_q.pop_front();
      b1 = rx_q.pop_front();
      b2 = rx_q.pop_front();
      b3 = rx_q.pop_front();
      start = st_q.pop_front();
      void'(st_q.pop_front());
      void'(st_q.pop_front());
      void'(st_q.pop_front());
      e1 = {4'h0, evt};
      check({tag, "_hdr"}, b0, 8'hA5);
      check({tag, "_evt"}, b1, e1);
      check({tag, "_status"}, b2, st);
      check({tag, "_cks"}, b3, e1 ^ st);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("wait_idle", o_busy, 1'b0);
  endtask

  initial begin
    int n, s1, s2, cnt_low, cnt_busy;
    logic [7:0] nst;
    logic [3:0] evt;
    logic req;

    do_reset();
    check("rst_tx", o_tx, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    check("rst_no_frame", rx_q.size(), 0);

    // Test 1: vol 0->3
    i_vol_level = 4'd3;
    @(posedge clk); #1;
    check("t1_tx_at_pend_edge", o_tx, 1'b1);
    @(posedge clk); #1;
    check("t1_tx_start", o_tx, 1'b0);
    check("t1_busy_start", o_busy, 1'b1);
    n = 1;
    while (o_busy && n < 1000) begin
      @(posedge clk); #1;
      if (o_busy) n++;
    end
    check("t1_busy_len", n, 400);
    expect_frame("t1", 4'h4, 8'h83, s1);

    // Test 2: song 0->2
    do_reset();
    i_song_select = 3'd2;
    expect_frame("t2", 4'h1, 8'hA0, s1);
    wait_idle();

    // Test 3: coalesce changes during a frame
    do_reset();
    i_vol_level = 4'd3;
    @(posedge clk);
    @(posedge clk);
    repeat (37) @(posedge clk);
    #1 i_pause = 1'b0;
    repeat (176) @(posedge clk);
    #1 i_vol_level = 4'd4;
    expect_frame("t3a", 4'h4, 8'h83, s1);
    expect_frame("t3b", 4'h6, 8'h04, s2);
    check("t3_gap", s2 - s1, 401);
    wait_idle();
    repeat (600) @(posedge clk);
    #1;
    check("t3_no_third", rx_q.size(), 0);

    // Test 4: request pulse without change
    i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    expect_frame("t4", 4'h8, 8'h04, s1);
    wait_idle();

    // Test 5: reset in the middle of byte 2
    i_vol_level = 4'd7;
    n = 0;
    while (o_tx && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_started", o_tx, 1'b0);
    repeat (250) @(posedge clk);
    #2 rst_n = 1'b0;
    i_pause = 1'b1;
    i_song_select = 3'd0;
    i_vol_level = 4'd0;
    #1;
    check("t5_rst_tx", o_tx, 1'b1);
    check("t5_rst_busy", o_busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rx_q.delete();
    st_q.delete();
    m_last = 8'h80;
    cnt_low = 0;
    cnt_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (!o_tx) cnt_low++;
      if (o_busy) cnt_busy++;
    end
    check("t5_no_low", cnt_low, 0);
    check("t5_no_busy", cnt_busy, 0);
    check("t5_no_bytes", rx_q.size(), 0);

    // Test 6: short vol glitch while idle
    i_vol_level = 4'd1;
    @(posedge clk); #1;
    i_vol_level = 4'd0;
    expect_frame("t6", 4'h4, 8'h80, s1);
    wait_idle();

    // Randomized single updates, each settled before the next
    do_reset();
    for (int it = 0; it < 12; it++) begin
      nst = {1'($urandom_range(1)), 3'($urandom_range(7)), 4'($urandom_range(8))};
      req = ($urandom_range(3) == 0);
      if (nst == m_last) req = 1'b1;
      evt = {req, nst[3:0] != m_last[3:0], nst[7] != m_last[7], nst[6:4] != m_last[6:4]};
      repeat ($urandom_range(5)) @(posedge clk);
      #1;
      i_pause = nst[7];
      i_song_select = nst[6:4];
      i_vol_level = nst[3:0];
      i_req = req;
      @(posedge clk); #1;
      i_req = 1'b0;
      expect_frame("rnd", evt, nst, s1);
      m_last = nst;
      wait_idle();
    end

    check("stop_bits", stop_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
